// File: rtl/nf10_pcap_replay_pkg.sv
// Shared definitions for the pcap replay micro-engine: arbiter state encoding,
// default queue count and a constant-evaluable ceil(log2) helper.
package nf10_pcap_replay_pkg;

  localparam int NQ = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // ceil(log2(value)), never less than 1 so single-bit selects stay legal
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotates the request vector so the search starts
// just after the previous winner, then takes the lowest set bit.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;

  always_comb begin
    start = (int'(last) + 1) % N;
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
    valid = |req;
    idx   = '0;
    // descending scan so the lowest rotated position is the one left standing
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = IW'((start + i) % N);
    end
  end

endmodule

// File: rtl/mem_wr_queue_arbiter.sv
// Packet-locked round-robin arbiter presenting one of several ingress FIFOs to the
// SRAM write engine, with per-queue packet counters and sticky oversize flags.
//
//   state  | meaning
//   IDLE   | no lock; pick next requesting queue after last_grant
//   LOCKED | granted queue streamed to write engine until EOP or word limit
module mem_wr_queue_arbiter
  import nf10_pcap_replay_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 72,
  parameter int FIFO_NUM_QUEUES = NQ,
  parameter int MAX_PKT_WORDS   = 256,
  parameter int CNT_WIDTH       = 32,
  localparam int QW  = log2(FIFO_NUM_QUEUES),
  localparam int WCW = log2(MAX_PKT_WORDS) + 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       sw_rst,
  input  logic [FIFO_NUM_QUEUES*FIFO_DATA_WIDTH-1:0] q_data,
  input  logic [FIFO_NUM_QUEUES-1:0]                 q_eop,
  input  logic [FIFO_NUM_QUEUES-1:0]                 q_empty,
  output logic [FIFO_NUM_QUEUES-1:0]                 q_rd_en,
  input  logic [FIFO_NUM_QUEUES-1:0]                 q_enable,
  output logic [FIFO_DATA_WIDTH-1:0]                 fifo_data,
  output logic [QW-1:0]                              fifo_qid,
  output logic                                       fifo_empty,
  input  logic                                       fifo_rd_en,
  output logic [FIFO_NUM_QUEUES*CNT_WIDTH-1:0]       pkt_cnt,
  output logic [FIFO_NUM_QUEUES-1:0]                 oversize_err
);

  localparam int             N        = FIFO_NUM_QUEUES;
  localparam logic [QW-1:0]  LAST_RST = QW'(N - 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(MAX_PKT_WORDS - 1);

  arb_state_t     state, state_nxt;
  logic [QW-1:0]  grant, grant_nxt;
  logic [QW-1:0]  last_grant, last_grant_nxt;
  logic [WCW-1:0] word_cnt, word_cnt_nxt;
  logic [N-1:0]   req;
  logic [N-1:0]   cnt_inc;
  logic [N-1:0]   err_set;
  logic           pick_valid;
  logic [QW-1:0]  pick_idx;
  logic           clear;

  assign clear = rst | sw_rst;
  assign req   = ~q_empty & q_enable;

  rr_priority_picker #(
    .N  (N),
    .IW (QW)
  ) u_picker (
    .req   (req),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // grant only changes on IDLE->LOCKED, so qid and data select are stable for the whole packet
  assign fifo_data = q_data[int'(grant)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
  assign fifo_qid  = grant;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    word_cnt_nxt   = word_cnt;
    cnt_inc        = '0;
    err_set        = '0;
    fifo_empty     = 1'b1;
    q_rd_en        = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt    = pick_idx;
          word_cnt_nxt = '0;
          state_nxt    = LOCKED;
        end
      end
      LOCKED: begin
        fifo_empty     = q_empty[grant];
        q_rd_en[grant] = fifo_rd_en;
        if (fifo_rd_en) begin
          if (q_eop[grant]) begin
            cnt_inc[grant] = 1'b1;
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else if (word_cnt == WC_LAST) begin
            err_set[grant] = 1'b1;
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else begin
            word_cnt_nxt = word_cnt + WCW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= LAST_RST;
      word_cnt     <= '0;
      pkt_cnt      <= '0;
      oversize_err <= '0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      last_grant   <= last_grant_nxt;
      word_cnt     <= word_cnt_nxt;
      oversize_err <= oversize_err | err_set;
      for (int i = 0; i < N; i++) begin
        if (cnt_inc[i]) begin
          pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
